seg_display_scheduler: RTL



---
 rtl/seg_display_pkg.sv | 36 +++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg_display_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and glyph table for the 7-segment display scheduler.
// Segment bit order is a..g = bit 0..6, active high.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seg7_hex_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 7-segment display between NUM_SRC sources:
// grant, blank gap, then show the latched nibble for a fixed dwell.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [4*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   grant,
  output logic [6:0]           segments,
  output logic                 dp,
  output logic [IDX_W-1:0]     src_idx,
  output logic                 busy
);

  localparam int unsigned PAD_W = 2**IDX_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   src_idx_d;
  logic [3:0]         nib_q, nib_d;
  logic [NUM_SRC-1:0] grant_d;
  logic [6:0]         seg_d;
  logic               dp_d, busy_d;
  logic [6:0]         glyph;

  logic [PAD_W-1:0]   req_pad;
  logic [PAD_W-1:0]   grant_pad;
  logic [3:0]         nib_arr [PAD_W];
  logic [IDX_W-1:0]   cand, win_idx;
  logic               win_valid, do_arb;

  // Pad request/data to a power of two so the arbiter index is exact-width.
  assign req_pad = PAD_W'(req);
  for (genvar j = 0; j < PAD_W; j++) begin : g_nib
    if (j < NUM_SRC) begin : g_src
      assign nib_arr[j] = src_data[4*j +: 4];
    end else begin : g_pad
      assign nib_arr[j] = '0;
    end
  end

  seg7_hex_decoder u_dec (
    .nibble (nib_q),
    .seg    (glyph)
  );

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] p,
                                               input int unsigned off);
    int unsigned s;
    s = (32'(p) + off) % NUM_SRC;
    return IDX_W'(s);
  endfunction

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = rr_next(rr_ptr_q, i);
      if (!win_valid && req_pad[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    src_idx_d = src_idx;
    nib_d     = nib_q;
    grant_pad = '0;
    do_arb    = 1'b0;

    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: do_arb = 1'b1;
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = CNT_W'(DWELL_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            do_arb  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_arb && win_valid) begin
      grant_pad[win_idx] = 1'b1;
      nib_d     = nib_arr[win_idx];
      src_idx_d = win_idx;
      rr_ptr_d  = win_idx;
      cnt_d     = CNT_W'(BLANK_CYCLES - 1);
      state_d   = BLANK;
    end

    // Outputs are registered, so they are derived from the next state.
    grant_d = grant_pad[NUM_SRC-1:0];
    busy_d  = (state_d != IDLE);
    dp_d    = (state_d == SHOW);
    seg_d   = (state_d == SHOW) ? glyph : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= IDX_W'(NUM_SRC - 1);
      nib_q    <= '0;
      src_idx  <= '0;
      grant    <= '0;
      segments <= SEG_BLANK;
      dp       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      nib_q    <= nib_d;
      src_idx  <= src_idx_d;
      grant    <= grant_d;
      segments <= seg_d;
      dp       <= dp_d;
      busy     <= busy_d;
    end
  end

endmodule
